// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with execute-stage operand selection.
// Latches decoded fields, forwards results from EX/MEM and MEM/WB to resolve
// RAW hazards, and requests a one-cycle decode stall on a load-use hazard.
module ex_operand_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_idx,
    input  logic [4:0]  id_rt_idx,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [15:0] id_imm16,
    input  logic [4:0]  id_shamt,
    input  logic [3:0]  id_alu_op,
    input  logic        id_src_imm,
    input  logic        id_zext,
    input  logic        id_shift,
    input  logic [4:0]  id_dest,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        stall,
    input  logic        flush,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_dest,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_dest,
    input  logic [31:0] mwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        load_use_stall
);

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        src_imm;
        logic        zext;
        logic        shift;
        logic [3:0]  op;
        logic [4:0]  dest;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [4:0]  shamt;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [15:0] imm16;
    } ex_reg_t;

    ex_reg_t     ex_q, id_d;
    logic [31:0] fwd_rs, fwd_rt, imm32;
    logic        lu_hit;

    // Pack the decode slot; control flags only count for a real instruction
    always_comb begin
        id_d           = '0;
        id_d.valid     = id_valid;
        id_d.reg_write = id_reg_write & id_valid;
        id_d.mem_read  = id_mem_read  & id_valid;
        id_d.mem_write = id_mem_write & id_valid;
        id_d.src_imm   = id_src_imm;
        id_d.zext      = id_zext;
        id_d.shift     = id_shift;
        id_d.op        = id_alu_op;
        id_d.dest      = id_dest;
        id_d.rs_idx    = id_rs_idx;
        id_d.rt_idx    = id_rt_idx;
        id_d.shamt     = id_shamt;
        id_d.rs_val    = id_rs_val;
        id_d.rt_val    = id_rt_val;
        id_d.imm16     = id_imm16;
    end

    // EX register: flush beats stall, stall beats the load-use bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ex_q <= '0;
        else if (flush)          ex_q <= '0;
        else if (stall)          ex_q <= ex_q;
        else if (load_use_stall) ex_q <= '0;
        else                     ex_q <= id_d;
    end

    // Bypass selection; EX/MEM is the younger result so it wins, r0 never forwards,
    // and an empty EX slot just shows its latched (zero after reset/bubble) values
    always_comb begin
        fwd_rs = ex_q.rs_val;
        fwd_rt = ex_q.rt_val;
        if (FWD_EN && ex_q.valid) begin
            if (ex_q.rs_idx != 5'd0 && exm_reg_write && exm_dest == ex_q.rs_idx)
                fwd_rs = exm_result;
            else if (ex_q.rs_idx != 5'd0 && mwb_reg_write && mwb_dest == ex_q.rs_idx)
                fwd_rs = mwb_result;
            if (ex_q.rt_idx != 5'd0 && exm_reg_write && exm_dest == ex_q.rt_idx)
                fwd_rt = exm_result;
            else if (ex_q.rt_idx != 5'd0 && mwb_reg_write && mwb_dest == ex_q.rt_idx)
                fwd_rt = mwb_result;
        end
    end

    // Operand muxing: shifts take rt on A and shamt on B
    always_comb begin
        imm32 = ex_q.zext ? {16'b0, ex_q.imm16} : {{16{ex_q.imm16[15]}}, ex_q.imm16};
        if (ex_q.shift) begin
            alu_a = fwd_rt;
            alu_b = {27'b0, ex_q.shamt};
        end else begin
            alu_a = fwd_rs;
            alu_b = ex_q.src_imm ? imm32 : fwd_rt;
        end
    end

    // Load-use: rt matters when it feeds B or is the store data
    always_comb begin
        lu_hit = ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) & id_valid &
                 ((ex_q.dest == id_rs_idx) |
                  ((ex_q.dest == id_rt_idx) & (~id_src_imm | id_mem_write)));
        load_use_stall = lu_hit & ~flush;
    end

    assign alu_op        = ex_q.op;
    assign ex_store_data = fwd_rt;
    assign ex_dest       = ex_q.dest;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios then random traffic, all
// compared against a behavioural model of the ID/EX slot.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 0, id_src_imm = 0, id_zext = 0, id_shift = 0;
    logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0;
    logic [4:0]  id_rs_idx = 0, id_rt_idx = 0, id_shamt = 0, id_dest = 0;
    logic [31:0] id_rs_val = 0, id_rt_val = 0;
    logic [15:0] id_imm16 = 0;
    logic [3:0]  id_alu_op = 0;
    logic        stall = 0, flush = 0;
    logic        exm_reg_write = 0, mwb_reg_write = 0;
    logic [4:0]  exm_dest = 0, mwb_dest = 0;
    logic [31:0] exm_result = 0, mwb_result = 0;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

    int n_chk = 0, n_pass = 0;

    ex_operand_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
        .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_src_imm(id_src_imm),
        .id_zext(id_zext), .id_shift(id_shift), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_dest(mwb_dest), .mwb_result(mwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently sitting in EX
    typedef struct {
        bit          valid, rw, mr, mw, src_imm, zext, shift;
        int unsigned op, dest, rs, rt, shamt, imm;
        bit [31:0]   rsv, rtv;
    } slot_t;
    slot_t m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic m_clear();
        m = '{default: 0};
    endtask

    function automatic bit [31:0] m_fwd(int unsigned idx, bit [31:0] v);
        if (!m.valid || idx == 0) return v;
        if (exm_reg_write && exm_dest == idx) return exm_result;
        if (mwb_reg_write && mwb_dest == idx) return mwb_result;
        return v;
    endfunction

    function automatic bit m_lus();
        bit rt_used;
        if (flush) return 1'b0;
        rt_used = !id_src_imm || id_mem_write;
        return m.valid && m.mr && m.dest != 0 && id_valid &&
               (m.dest == id_rs_idx || (rt_used && m.dest == id_rt_idx));
    endfunction

    task automatic m_clock();
        if (flush) m_clear();
        else if (stall) ;
        else if (m_lus()) m_clear();
        else begin
            m.valid = id_valid; m.rw = id_reg_write && id_valid;
            m.mr = id_mem_read && id_valid; m.mw = id_mem_write && id_valid;
            m.src_imm = id_src_imm; m.zext = id_zext; m.shift = id_shift;
            m.op = id_alu_op; m.dest = id_dest; m.rs = id_rs_idx; m.rt = id_rt_idx;
            m.shamt = id_shamt; m.imm = id_imm16; m.rsv = id_rs_val; m.rtv = id_rt_val;
        end
    endtask

    task automatic check_model();
        bit [31:0] frs, frt, imm32, ea, eb;
        int signed simm;
        frs = m_fwd(m.rs, m.rsv);
        frt = m_fwd(m.rt, m.rtv);
        simm = (m.imm >= 32768) ? int'(m.imm) - 65536 : int'(m.imm);
        imm32 = m.zext ? 32'(m.imm) : 32'(simm);
        if (m.shift) begin ea = frt; eb = 32'(m.shamt); end
        else begin ea = frs; eb = m.src_imm ? imm32 : frt; end
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", 32'(alu_op), m.op);
        chk("store", ex_store_data, frt);
        chk("ctl", {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall},
            {27'b0, m.valid, m.rw, m.mr, m.mw, m_lus()});
        chk("dest", 32'(ex_dest), m.dest);
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        #2;
        check_model();
    endtask

    task automatic id_clear();
        id_valid = 0; id_src_imm = 0; id_zext = 0; id_shift = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        id_rs_idx = 0; id_rt_idx = 0; id_shamt = 0; id_dest = 0;
        id_rs_val = 0; id_rt_val = 0; id_imm16 = 0; id_alu_op = 0;
        exm_reg_write = 0; mwb_reg_write = 0; exm_dest = 0; mwb_dest = 0;
    endtask

    initial begin
        logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd12};
        m_clear();
        // Reset: load something, then drop rst_n mid-cycle
        #12 rst_n = 1'b1;
        id_valid = 1; id_reg_write = 1; id_alu_op = 4'd7; id_dest = 5'd3; id_rs_val = 32'h99;
        tick();
        #1 rst_n = 1'b0;
        #1 m_clear();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_op", 32'(alu_op), 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_lus", 32'(load_use_stall), 0);
        #1 rst_n = 1'b1;
        id_clear();

        // ADDI sign-extended
        id_valid = 1; id_rs_idx = 3; id_rs_val = 32'h10; id_imm16 = 16'hFFFF;
        id_src_imm = 1; id_alu_op = 4'd2;
        tick();
        chk("addi_a", alu_a, 32'h10);
        chk("addi_b", alu_b, 32'hFFFF_FFFF);
        chk("addi_op", 32'(alu_op), 2);

        // Forward priority on rs=5
        id_src_imm = 0; id_rs_idx = 5; id_rs_val = 32'h77;
        tick();
        exm_reg_write = 1; exm_dest = 5; exm_result = 32'hAAAA;
        mwb_reg_write = 1; mwb_dest = 5; mwb_result = 32'hBBBB;
        #1 chk("fwd_exm", alu_a, 32'hAAAA);
        exm_reg_write = 0;
        #1 chk("fwd_mwb", alu_a, 32'hBBBB);
        exm_reg_write = 1; exm_dest = 0; mwb_dest = 0;
        id_rs_idx = 0; id_rs_val = 32'h55;
        tick();
        chk("fwd_r0", alu_a, 32'h55);

        // SLL
        id_clear();
        id_valid = 1; id_shift = 1; id_rt_idx = 2; id_rt_val = 32'h1; id_shamt = 4; id_alu_op = 4'd3;
        tick();
        chk("sll_a", alu_a, 32'h1);
        chk("sll_b", alu_b, 32'h4);

        // Load-use: LW r8 then ADD r10 = r8 + r9
        id_clear();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_dest = 8; id_rs_idx = 1;
        id_src_imm = 1; id_alu_op = 4'd2;
        tick();
        id_clear();
        id_valid = 1; id_reg_write = 1; id_rs_idx = 8; id_rt_idx = 9; id_dest = 10; id_alu_op = 4'd2;
        #1 chk("lu_req", 32'(load_use_stall), 1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 0);
        mwb_reg_write = 1; mwb_dest = 8; mwb_result = 32'h1234;
        tick();
        chk("lu_valid", 32'(ex_valid), 1);
        chk("lu_fwd", alu_a, 32'h1234);

        // Flush and stall together
        flush = 1; stall = 1;
        tick();
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_rw", 32'(ex_reg_write), 0);
        flush = 0; stall = 0;

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs_idx = 5'($urandom_range(0, 7)); id_rt_idx = 5'($urandom_range(0, 7));
            id_dest = 5'($urandom_range(0, 7));
            id_rs_val = $urandom; id_rt_val = $urandom; id_imm16 = 16'($urandom);
            id_shamt = 5'($urandom); id_alu_op = ops[$urandom_range(0, 7)];
            id_src_imm = 1'($urandom); id_zext = 1'($urandom);
            id_shift = ($urandom_range(0, 4) == 0);
            id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
            id_mem_write = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 15) == 0);
            exm_reg_write = 1'($urandom); exm_dest = 5'($urandom_range(0, 7)); exm_result = $urandom;
            mwb_reg_write = 1'($urandom); mwb_dest = 5'($urandom_range(0, 7)); mwb_result = $urandom;
            #1 check_model();
            tick();
            if (i == 200) begin
                // Reset while stalled clears with no clock edge
                stall = 1;
                #1 rst_n = 1'b0;
                #1 m_clear();
                chk("rst_stall", 32'(ex_valid), 0);
                check_model();
                #1 rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
